rect_layer: RTL

- Multi-rectangle overlay stage for the VGA timing pipeline; generalises the single fixed-size rectangle stage to NUM_RECTS independently placed, sized and coloured rectangles.
- Sits between the background/pointer stages and the output register.
- Geometry is shadow-latched once per frame at the start of vertical blanking, so no tearing occurs mid-frame.
- Two-stage pipeline; all timing signals are delayed to match.

---
 rtl/rect_layer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rect_layer.sv
// Multi-rectangle overlay stage: per-frame shadow-latched geometry, two-stage pixel pipeline.
// Optional blinking is enabled by defining RECT_BLINK_EN.
module rect_layer #(
  parameter int unsigned NUM_RECTS    = 4,
  parameter int unsigned COLOR_W      = 12,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [10:0]                    hcount_in,
  input  logic [10:0]                    vcount_in,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  input  logic                           hblnk_in,
  input  logic                           vblnk_in,
  input  logic [COLOR_W-1:0]             rgb_in,
  input  logic [NUM_RECTS*11-1:0]        xpos_in,
  input  logic [NUM_RECTS*11-1:0]        ypos_in,
  input  logic [NUM_RECTS*11-1:0]        width_in,
  input  logic [NUM_RECTS*11-1:0]        height_in,
  input  logic [NUM_RECTS*COLOR_W-1:0]   color_in,
  input  logic [NUM_RECTS-1:0]           enable_in,
  input  logic [NUM_RECTS-1:0]           blink_in,
  output logic [10:0]                    hcount_out,
  output logic [10:0]                    vcount_out,
  output logic                           hsync_out,
  output logic                           vsync_out,
  output logic                           hblnk_out,
  output logic                           vblnk_out,
  output logic [COLOR_W-1:0]             rgb_out,
  output logic                           frame_latch
);

  localparam int unsigned N = NUM_RECTS;

  logic [N*11-1:0]      sx_q, sy_q, sw_q, sh_q;
  logic [N*COLOR_W-1:0] sc_q;
  logic [N-1:0]         se_q;
  logic                 vblnk_q, frame_latch_q, latch;
  logic [N-1:0]         vis;

  assign latch = vblnk_in & ~vblnk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q       <= 1'b0;
      frame_latch_q <= 1'b0;
      sx_q <= '0; sy_q <= '0; sw_q <= '0; sh_q <= '0;
      sc_q <= '0; se_q <= '0;
    end else begin
      vblnk_q       <= vblnk_in;
      frame_latch_q <= latch;
      if (latch) begin
        sx_q <= xpos_in;  sy_q <= ypos_in;
        sw_q <= width_in; sh_q <= height_in;
        sc_q <= color_in; se_q <= enable_in;
      end
    end
  end

`ifdef RECT_BLINK_EN
  localparam int unsigned FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FCW-1:0] fcnt_q;
  logic           phase_q;
  logic [N-1:0]   sb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q  <= '0;
      phase_q <= 1'b1;
      sb_q    <= '0;
    end else if (latch) begin
      sb_q <= blink_in;
      if (fcnt_q == FCW'(BLINK_FRAMES - 1)) begin
        fcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  assign vis = phase_q ? '1 : ~sb_q;
`else
  logic unused_blink;
  assign unused_blink = (^blink_in) | (BLINK_FRAMES == 0);
  assign vis = '1;
`endif

  // Stage 1: 12-bit bounds so rects running past 2047 clip instead of wrapping
  logic [N-1:0]         hit1_d, hit1_q;
  logic [10:0]          hc1_q, vc1_q;
  logic                 hs1_q, vs1_q, hb1_q, vb1_q;
  logic [COLOR_W-1:0]   rgb1_q;

  always_comb begin
    hit1_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hit1_d[i] = se_q[i] & vis[i]
        & ({1'b0, hcount_in} >= {1'b0, sx_q[i*11 +: 11]})
        & ({1'b0, hcount_in} <  ({1'b0, sx_q[i*11 +: 11]} + {1'b0, sw_q[i*11 +: 11]}))
        & ({1'b0, vcount_in} >= {1'b0, sy_q[i*11 +: 11]})
        & ({1'b0, vcount_in} <  ({1'b0, sy_q[i*11 +: 11]} + {1'b0, sh_q[i*11 +: 11]}));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit1_q <= '0; hc1_q <= '0; vc1_q <= '0;
      hs1_q <= 1'b0; vs1_q <= 1'b0; hb1_q <= 1'b0; vb1_q <= 1'b0;
      rgb1_q <= '0;
    end else begin
      hit1_q <= hit1_d; hc1_q <= hcount_in; vc1_q <= vcount_in;
      hs1_q <= hsync_in; vs1_q <= vsync_in; hb1_q <= hblnk_in; vb1_q <= vblnk_in;
      rgb1_q <= rgb_in;
    end
  end

  // Stage 2: scan from highest index down so the lowest set index is assigned last
  logic [COLOR_W-1:0] rgb2_d, rgb2_q;
  logic [10:0]        hc2_q, vc2_q;
  logic               hs2_q, vs2_q, hb2_q, vb2_q;

  always_comb begin
    rgb2_d = rgb1_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (hit1_q[N-1-k]) rgb2_d = sc_q[(N-1-k)*COLOR_W +: COLOR_W];
    end
    if (hb1_q | vb1_q) rgb2_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb2_q <= '0; hc2_q <= '0; vc2_q <= '0;
      hs2_q <= 1'b0; vs2_q <= 1'b0; hb2_q <= 1'b0; vb2_q <= 1'b0;
    end else begin
      rgb2_q <= rgb2_d; hc2_q <= hc1_q; vc2_q <= vc1_q;
      hs2_q <= hs1_q; vs2_q <= vs1_q; hb2_q <= hb1_q; vb2_q <= vb1_q;
    end
  end

  assign hcount_out  = hc2_q;
  assign vcount_out  = vc2_q;
  assign hsync_out   = hs2_q;
  assign vsync_out   = vs2_q;
  assign hblnk_out   = hb2_q;
  assign vblnk_out   = vb2_q;
  assign rgb_out     = rgb2_q;
  assign frame_latch = frame_latch_q;

endmodule
